// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU control and the
// iterative multiply/divide sequencer.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_MFHI = 4'b0110;
    localparam logic [3:0] ALU_MFLO = 4'b0111;
    localparam logic [3:0] ALU_MD   = 4'b1000;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    localparam logic [5:0] F_ADD   = 6'b100010;
    localparam logic [5:0] F_SUB   = 6'b100000;
    localparam logic [5:0] F_AND   = 6'b100101;
    localparam logic [5:0] F_OR    = 6'b100100;
    localparam logic [5:0] F_NOR   = 6'b101010;
    localparam logic [5:0] F_SLT   = 6'b100111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_ADD = 2'b01;
    localparam logic [1:0] ALUOP_BEQ = 2'b10;
    localparam logic [1:0] ALUOP_BNE = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;
    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_kind_t;

    // mul/div functs 0110xx map directly onto md_kind_t through their low bits
    function automatic md_kind_t funct_to_kind(input logic [5:0] f);
        return md_kind_t'(f[1:0]);
    endfunction

endpackage

// File: rtl/alu_ctrl_md_iter.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per step_i cycle, DATA_W steps per op.
module md_iter_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] b_q;
    logic              is_div_q;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic              fits;

    always_comb begin
        sum     = {1'b0, acc} + {1'b0, b_q};
        shifted = {acc, lo[DATA_W-1]};
        fits    = shifted >= {1'b0, b_q};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            acc      <= '0;
            lo       <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
        end else if (load_i) begin
            cnt      <= CNT_W'(DATA_W);
            acc      <= '0;
            lo       <= a_i;
            b_q      <= b_i;
            is_div_q <= is_div_i;
        end else if (step_i && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div_q) begin
                // lo doubles as dividend shifter and quotient collector
                if (fits) acc <= shifted[DATA_W-1:0] - b_q;
                else      acc <= shifted[DATA_W-1:0];
                lo <= {lo[DATA_W-2:0], fits};
            end else if (lo[0]) begin
                {acc, lo} <= {sum, lo[DATA_W-1:1]};
            end else begin
                {acc, lo} <= {1'b0, acc, lo[DATA_W-1:1]};
            end
        end
    end

    assign done_o = step_i && (cnt == CNT_W'(1));
    assign hi_o   = acc;
    assign lo_o   = lo;

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU control with non-blocking iterative mul/div and HI/LO.
// Only dependent HI/LO reads or a second mul/div stall while busy.
module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              stall_o,
    output logic              md_busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_zero_o
);
    md_state_t         state, state_nx;
    md_kind_t          kind_in;
    logic              md_op, hl_op, issue, is_signed, is_div, it_done;
    logic              neg_q, neg_r, div0_q;
    logic [DATA_W-1:0] rs_q, a_mag, b_mag, it_hi, it_lo, hi_q, lo_q;
    logic [2*DATA_W-1:0] prod;
    logic [3:0]        ctrl;

    always_comb begin
        ctrl = ALU_BAD;
        case (ALUOp_i)
            ALUOP_R: begin
                case (funct_i)
                    F_ADD:  ctrl = ALU_ADD;
                    F_SUB:  ctrl = ALU_SUB;
                    F_AND:  ctrl = ALU_AND;
                    F_OR:   ctrl = ALU_OR;
                    F_NOR:  ctrl = ALU_NOR;
                    F_SLT:  ctrl = ALU_SLT;
                    F_MFHI: ctrl = ALU_MFHI;
                    F_MFLO: ctrl = ALU_MFLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ctrl = ALU_MD;
                    default: ctrl = ALU_BAD;
                endcase
            end
            ALUOP_ADD: ctrl = ALU_ADD;
            default:   ctrl = ALU_SUB;
        endcase
    end
    assign ALUCtrl_o = CTRL_W'(ctrl);

    assign md_op = valid_i && (ALUOp_i == ALUOP_R) &&
                   (funct_i inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign hl_op = valid_i && (ALUOp_i == ALUOP_R) &&
                   (funct_i inside {F_MFHI, F_MFLO});
    assign stall_o   = (md_op || hl_op) && (state != IDLE);
    assign issue     = md_op && (state == IDLE);
    assign md_busy_o = (state != IDLE);

    assign kind_in   = funct_to_kind(funct_i);
    assign is_signed = (kind_in == MD_MULT) || (kind_in == MD_DIV);
    assign is_div    = (kind_in == MD_DIV) || (kind_in == MD_DIVU);
    assign a_mag = (is_signed && rs_data_i[DATA_W-1]) ? -rs_data_i : rs_data_i;
    assign b_mag = (is_signed && rt_data_i[DATA_W-1]) ? -rt_data_i : rt_data_i;

    md_iter_unit #(.DATA_W(DATA_W)) u_iter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (issue),
        .step_i   (state == RUN),
        .is_div_i (is_div),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .done_o   (it_done),
        .hi_o     (it_hi),
        .lo_o     (it_lo)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (issue) state_nx = RUN;
            RUN:     if (it_done) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign prod       = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign div_zero_o = (state == FIX) && div0_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_q <= 1'b0;
            rs_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                neg_q  <= is_signed && (rs_data_i[DATA_W-1] ^ rt_data_i[DATA_W-1]);
                neg_r  <= is_signed && rs_data_i[DATA_W-1];
                div0_q <= is_div && (rt_data_i == '0);
                rs_q   <= rs_data_i;
            end
            if (state == FIX) begin
                if (!u_iter.is_div_q) begin
                    {hi_q, lo_q} <= prod;
                end else if (div0_q) begin
                    hi_q <= rs_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= neg_r ? -it_hi : it_hi;
                    lo_q <= neg_q ? -it_lo : it_lo;
                end
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode sweep, mul/div results and
// latency, stall behaviour and mid-operation reset.
`timescale 1ns/1ps
module tb_alu_ctrl_md;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [1:0]        ALUOp_i = 2'b00;
    logic [5:0]        funct_i = 6'b0;
    logic [DATA_W-1:0] rs_data_i = '0;
    logic [DATA_W-1:0] rt_data_i = '0;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              stall_o, md_busy_o, div_zero_o;
    logic [DATA_W-1:0] hi_o, lo_o;

    int n_chk  = 0;
    int n_fail = 0;

    alu_ctrl_md #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ALUOp_i    (ALUOp_i),
        .funct_i    (funct_i),
        .rs_data_i  (rs_data_i),
        .rt_data_i  (rt_data_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .stall_o    (stall_o),
        .md_busy_o  (md_busy_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // issue at T, check busy/div_zero over T+1..T+33 and results at T+34
    task automatic run_md(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz);
        int busy_cnt, dz_cnt;
        logic dz_fix;
        valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = f;
        rs_data_i = a; rt_data_i = b;
        #1;
        chk_eq({tag, "_issue_stall"}, stall_o, 1'b0);
        tick();
        valid_i = 1'b0;
        rs_data_i = 32'hDEADBEEF; rt_data_i = 32'h12345678;
        busy_cnt = 0; dz_cnt = 0; dz_fix = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            busy_cnt += int'(md_busy_o);
            dz_cnt   += int'(div_zero_o);
            if (k == 33) dz_fix = div_zero_o;
            tick();
        end
        chk_eq({tag, "_busy_cycles"}, busy_cnt, 33);
        chk_eq({tag, "_dz_pulses"}, dz_cnt, {63'b0, exp_dz});
        chk_eq({tag, "_dz_at_fix"}, dz_fix, exp_dz);
        chk_eq({tag, "_busy_done"}, md_busy_o, 1'b0);
        chk_eq({tag, "_hi"}, hi_o, exp_hi);
        chk_eq({tag, "_lo"}, lo_o, exp_lo);
    endtask

    logic [5:0] dec_f [14] = '{6'b100010, 6'b100000, 6'b100101, 6'b100100, 6'b101010,
                               6'b100111, 6'b010000, 6'b010010, 6'b011000, 6'b011001,
                               6'b011010, 6'b011011, 6'b111111, 6'b000000};
    logic [3:0] dec_e [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h8, 4'h8, 4'h8, 4'hF, 4'hF};

    initial begin
        int stall_cnt;
        tick(); tick();
        chk_eq("rst_hi", hi_o, 32'h0);
        chk_eq("rst_lo", lo_o, 32'h0);
        chk_eq("rst_busy", md_busy_o, 1'b0);
        chk_eq("rst_dz", div_zero_o, 1'b0);
        rst_i = 1'b1;
        tick();

        // decode sweep with valid_i low so mul/div functs do not issue
        for (int i = 0; i < 14; i++) begin
            ALUOp_i = 2'b00; funct_i = dec_f[i];
            #1;
            chk_eq($sformatf("dec_r_%0d", i), ALUCtrl_o, dec_e[i]);
            chk_eq($sformatf("dec_stall_%0d", i), stall_o, 1'b0);
            tick();
        end
        funct_i = 6'b100101;
        for (int i = 1; i < 4; i++) begin
            ALUOp_i = 2'(i);
            #1;
            chk_eq($sformatf("dec_op_%0d", i), ALUCtrl_o, (i == 1) ? 64'h0 : 64'h1);
            tick();
        end

        run_md("mult",   6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_md("multu",  6'b011001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0);
        run_md("div",    6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_md("divu",   6'b011011, 32'd7,        32'd2, 32'd1,        32'd3,        1'b0);
        run_md("divmin", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_md("div0",   6'b011010, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 1'b1);

        // dependent mflo stalls through FIX; an add in between never stalls
        valid_i = 1'b1; ALUOp_i = 2'b00; funct_i = 6'b011000;
        rs_data_i = 32'd6; rt_data_i = 32'd7;
        tick();
        stall_cnt = 0;
        for (int k = 1; k <= 33; k++) begin
            funct_i = (k == 10) ? 6'b100010 : 6'b010010;
            #1;
            if (k == 10) chk_eq("busy_add_stall", stall_o, 1'b0);
            else         stall_cnt += int'(stall_o);
            tick();
        end
        funct_i = 6'b010010;
        #1;
        chk_eq("mflo_stall_cycles", stall_cnt, 32);
        chk_eq("mflo_release", stall_o, 1'b0);
        chk_eq("mflo_lo", lo_o, 32'd42);
        chk_eq("mflo_ctrl", ALUCtrl_o, 4'h7);
        tick();
        valid_i = 1'b0;

        // reset at T+10 of a divide aborts without touching HI/LO
        valid_i = 1'b1; funct_i = 6'b011011;
        rs_data_i = 32'd100; rt_data_i = 32'd7;
        tick();
        valid_i = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        chk_eq("abort_busy", md_busy_o, 1'b0);
        chk_eq("abort_hi", hi_o, 32'h0);
        chk_eq("abort_lo", lo_o, 32'h0);
        tick();
        chk_eq("abort_busy_after", md_busy_o, 1'b0);
        run_md("post_rst", 6'b011001, 32'h00010001, 32'h00010000, 32'h1, 32'h00010000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
Next-generation ALU control for the EX stage. It keeps the existing single-cycle ALU decode and adds a parametrised iterative multiply/divide sequencer with HI/LO registers (mult, multu, div, divu, mfhi, mflo).
- Multiply/divide ops issue without stalling.
- Only a dependent HI/LO access, or a second mul/div op, stalls the pipeline while the unit is busy.

Parameters:
DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W
CTRL_W, 4, width of ALUCtrl_o

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous active-low reset
valid_i  input  1  a valid instruction is present in EX this cycle
ALUOp_i  input  2  00 R-type, 01 add (lw/sw/addi), 10 sub (beq), 11 sub (bne)
funct_i  input  6  R-type function field
rs_data_i  input  DATA_W  dividend / multiplicand
rt_data_i  input  DATA_W  divisor / multiplier
ALUCtrl_o  output  CTRL_W  ALU operation select (combinational)
stall_o  output  1  hold IF/ID/EX this cycle (combinational)
md_busy_o  output  1  sequencer not IDLE (registered)
hi_o  output  DATA_W  HI register
lo_o  output  DATA_W  LO register
div_zero_o  output  1  one-cycle pulse, divide by zero completed

Behaviour:
- Reset (rst_i=0 at edge): state IDLE, HI=LO=0, counter=0, div_zero_o=0, md_busy_o=0. Reset mid-operation aborts it; no HI/LO write.
- Decode, ALUOp 00:
  - 100010->0000 add, 100000->0001 sub, 100101->0010 and, 100100->0011 or, 101010->0100 nor, 100111->0101 slt
  - 010000 (mfhi)->0110, 010010 (mflo)->0111
  - 011000/011001/011010/011011 (mult/multu/div/divu)->1000 (ALU idle)
  - any other funct->1111
- Decode, other ALUOp: 01->0000; 10 and 11->0001.
- md_op = mult/multu/div/divu; hl_op = mfhi/mflo; both qualified by valid_i and ALUOp 00.
- stall_o = valid_i & (md_op | hl_op) & (state != IDLE). All other ops never stall.
- FSM IDLE -> RUN -> FIX -> IDLE:
  - IDLE: on md_op, latch |rs| and |rt| (signed ops) or raw values (unsigned), result signs, op kind, counter=DATA_W; go RUN.
  - RUN: one radix-2 step per cycle (shift-add multiply or restoring divide); counter decrements; at counter==1 go FIX.
  - FIX: apply sign correction and write HI/LO at end of cycle; go IDLE.
- Latency: issue at cycle T; RUN T+1..T+DATA_W; FIX T+DATA_W+1; new HI/LO visible on hi_o/lo_o from T+DATA_W+2. A stalled mfhi/mflo proceeds in that cycle.
- md_busy_o is high from T+1 through the FIX cycle inclusive.
- Multiply result: {HI,LO} = 2*DATA_W product. Signed product is negated when sign(rs) xor sign(rt).
- Divide result: LO=quotient, HI=remainder.
  - Signed quotient is negative iff sign(rs) xor sign(rt); remainder takes the sign of rs.
  - MIN / -1: LO=MIN, HI=0. This falls out of the abs-value datapath; no special case.
- Divide by zero: no iteration shortcut, same latency. LO=all ones, HI=rs (original value). div_zero_o pulses in the FIX cycle.
- Simultaneous events:
  - md_op arriving during RUN/FIX stalls, then issues in the first IDLE cycle.
  - md_op in IDLE issues even when the previous result was written that same edge.
- Operands are sampled only in the IDLE issue cycle; later changes on rs/rt are ignored.
- HI/LO change only at FIX. mfhi/mflo in IDLE read the current registers.

Decomposition:
- Package alu_ctrl_pkg:
  - ALUCtrl code constants (0000..1000, 1111)
  - funct constants, ALUOp constants
  - FSM state type {IDLE, RUN, FIX}
  - md op kind type {MULT, MULTU, DIV, DIVU}
- One sub-module md_iter_unit: iterative shift-add/restoring datapath with counter, accumulator and done flag. The top owns decode, stall, FSM, sign handling and HI/LO.

Test Plan:
- Decode sweep, ALUOp 00 with each listed funct plus 111111, then ALUOp 01/10/11 -> exact codes above, stall_o=0 in all cases.
- mult rs=0xFFFFFFFE, rt=3 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu rs=7, rt=2 -> LO=3, HI=1; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- div rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5, div_zero_o high exactly in cycle T+33.
- Issue mult at T, present mflo at T+1 -> stall_o high T+1..T+33, low at T+34 with lo_o holding the new product; an add presented during busy -> stall_o=0.
- rst_i low at T+10 of a div -> IDLE, HI=LO=0, md_busy_o=0 next cycle; a fresh multu then completes normally.
